// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 register configuration path.
package ov5640_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FETCH,
        ST_WAIT_ACK,
        ST_DELAY,
        ST_NEXT,
        ST_RETRY,
        ST_DONE,
        ST_ERR
    } cfg_state_e;

    localparam logic [15:0] DELAY_ADDR = 16'hFFFF;
    localparam int unsigned CLK_PER_MS_DEF = 50_000;

    localparam int TBL_ADDR_MSB = 23;
    localparam int TBL_ADDR_LSB = 8;
    localparam int TBL_DATA_MSB = 7;
    localparam int TBL_DATA_LSB = 0;

    function automatic logic [23:0] tbl_word(
        input logic [15:0] addr,
        input logic [7:0]  data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// Combinational OV5640 init table; unused slots are 0 ms delay entries,
// which the controller walks through as one-cycle no-ops.
module ov5640_cfg_rom (
    input  logic [7:0]  idx_i,
    output logic [23:0] word_o
);
    import ov5640_pkg::*;

    always_comb begin
        word_o = tbl_word(DELAY_ADDR, 8'h00);
        case (idx_i)
            8'd0:  word_o = tbl_word(16'h3103, 8'h11);
            8'd1:  word_o = tbl_word(16'h3008, 8'h82);
            8'd2:  word_o = tbl_word(DELAY_ADDR, 8'h05);
            8'd3:  word_o = tbl_word(16'h3008, 8'h42);
            8'd4:  word_o = tbl_word(16'h3103, 8'h03);
            8'd5:  word_o = tbl_word(16'h3017, 8'hFF);
            8'd6:  word_o = tbl_word(16'h3018, 8'hFF);
            8'd7:  word_o = tbl_word(16'h3034, 8'h1A);
            8'd8:  word_o = tbl_word(16'h3035, 8'h11);
            8'd9:  word_o = tbl_word(16'h3036, 8'h46);
            8'd10: word_o = tbl_word(16'h3037, 8'h13);
            8'd11: word_o = tbl_word(16'h3108, 8'h01);
            8'd12: word_o = tbl_word(16'h3630, 8'h36);
            8'd13: word_o = tbl_word(16'h3631, 8'h0E);
            8'd14: word_o = tbl_word(16'h3632, 8'hE2);
            8'd15: word_o = tbl_word(16'h3633, 8'h12);
            8'd16: word_o = tbl_word(16'h3621, 8'hE0);
            8'd17: word_o = tbl_word(16'h3704, 8'hA0);
            8'd18: word_o = tbl_word(16'h3703, 8'h5A);
            8'd19: word_o = tbl_word(16'h3715, 8'h78);
            8'd20: word_o = tbl_word(16'h3717, 8'h01);
            8'd21: word_o = tbl_word(16'h370B, 8'h60);
            8'd22: word_o = tbl_word(16'h3705, 8'h1A);
            8'd23: word_o = tbl_word(16'h3905, 8'h02);
            8'd24: word_o = tbl_word(16'h3906, 8'h10);
            8'd25: word_o = tbl_word(16'h3901, 8'h0A);
            8'd26: word_o = tbl_word(16'h4300, 8'h61);
            8'd27: word_o = tbl_word(16'h501F, 8'h01);
            8'd28: word_o = tbl_word(16'h4740, 8'h21);
            8'd29: word_o = tbl_word(16'h3820, 8'h40);
            8'd30: word_o = tbl_word(16'h3821, 8'h06);
            8'd31: word_o = tbl_word(16'h3008, 8'h02);
            default: word_o = tbl_word(DELAY_ADDR, 8'h00);
        endcase
    end

endmodule

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 register configuration sequencer: table walk, SCCB req/ack, delays.
// Define OV5640_CFG_RETRY_EN to retry NACKed writes up to 3 times per entry.
module ov5640_cfg_ctrl #(
    parameter int unsigned TBL_DEPTH   = 252,
    parameter int unsigned CLK_PER_MS  = ov5640_pkg::CLK_PER_MS_DEF,
    parameter int unsigned SETTLE_MS   = 20,
    parameter int unsigned ACK_TIMEOUT = 100_000,
    parameter logic [15:0] DELAY_ADDR  = ov5640_pkg::DELAY_ADDR
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        power_done,
    output logic [7:0]  tbl_idx,
    input  logic [23:0] tbl_data,
    output logic        sccb_req,
    output logic [15:0] sccb_addr,
    output logic [7:0]  sccb_wdata,
    input  logic        sccb_ack,
    input  logic        sccb_nack,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        cfg_busy
);
    import ov5640_pkg::*;

    localparam int MSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int TOW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [MSW-1:0] MS_LAST  = MSW'(CLK_PER_MS - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]     IDX_LAST = 8'(TBL_DEPTH - 1);

    cfg_state_e     state_q;
    logic [7:0]     tbl_idx_q;
    logic           req_q;
    logic [15:0]    addr_q;
    logic [7:0]     wdata_q;
    logic           done_q;
    logic           err_q;
    logic [MSW-1:0] ms_cnt_q;
    logic [7:0]     dly_q;
    logic [TOW-1:0] to_q;
`ifdef OV5640_CFG_RETRY_EN
    logic [1:0]     retry_q;
`endif

    logic        busy_d;
    logic        ms_last_d;
    logic        cnt_done_d;
    logic        fetch_dly_d;
    logic [15:0] fetch_addr_d;
    logic [7:0]  fetch_data_d;
    cfg_state_e  cnt_tgt_d;

    assign busy_d = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign ms_last_d = (ms_cnt_q == MS_LAST);
    // dly_q holds whole ms still to wait; 0 means leave after one cycle
    assign cnt_done_d = (dly_q == 8'd0) || (ms_last_d && dly_q == 8'd1);
    assign fetch_addr_d = tbl_data[TBL_ADDR_MSB:TBL_ADDR_LSB];
    assign fetch_data_d = tbl_data[TBL_DATA_MSB:TBL_DATA_LSB];
    assign fetch_dly_d = (fetch_addr_d == DELAY_ADDR);
    assign cnt_tgt_d = (state_q == ST_DELAY) ? ST_NEXT : ST_FETCH;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            tbl_idx_q <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ms_cnt_q  <= '0;
            dly_q     <= '0;
            to_q      <= '0;
`ifdef OV5640_CFG_RETRY_EN
            retry_q   <= '0;
`endif
        end else if (busy_d && !power_done) begin
            state_q   <= ST_IDLE;
            tbl_idx_q <= '0;
            req_q     <= 1'b0;
            ms_cnt_q  <= '0;
            dly_q     <= '0;
            to_q      <= '0;
`ifdef OV5640_CFG_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (power_done) begin
                        state_q  <= ST_SETTLE;
                        ms_cnt_q <= '0;
                        dly_q    <= 8'(SETTLE_MS);
                    end
                end
`ifdef OV5640_CFG_RETRY_EN
                ST_SETTLE, ST_DELAY, ST_RETRY: begin
`else
                ST_SETTLE, ST_DELAY: begin
`endif
                    if (cnt_done_d) begin
                        state_q  <= cnt_tgt_d;
                        ms_cnt_q <= '0;
                    end else if (ms_last_d) begin
                        ms_cnt_q <= '0;
                        dly_q    <= dly_q - 8'd1;
                    end else begin
                        ms_cnt_q <= ms_cnt_q + MSW'(1);
                    end
                end
                ST_FETCH: begin
                    to_q <= '0;
                    if (fetch_dly_d) begin
                        dly_q    <= fetch_data_d;
                        ms_cnt_q <= '0;
                        state_q  <= ST_DELAY;
                    end else begin
                        addr_q  <= fetch_addr_d;
                        wdata_q <= fetch_data_d;
                        req_q   <= 1'b1;
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sccb_ack) begin
                        req_q <= 1'b0;
                        if (!sccb_nack) begin
                            state_q <= ST_NEXT;
`ifdef OV5640_CFG_RETRY_EN
                        end else if (retry_q != 2'd3) begin
                            retry_q  <= retry_q + 2'd1;
                            dly_q    <= 8'd1;
                            ms_cnt_q <= '0;
                            state_q  <= ST_RETRY;
`endif
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end else if (to_q == TO_LAST) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        to_q <= to_q + TOW'(1);
                    end
                end
                ST_NEXT: begin
`ifdef OV5640_CFG_RETRY_EN
                    retry_q <= '0;
`endif
                    if (tbl_idx_q == IDX_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tbl_idx_q <= tbl_idx_q + 8'd1;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_DONE, ST_ERR: begin
                    req_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tbl_idx    = tbl_idx_q;
    assign sccb_req   = req_q;
    assign sccb_addr  = addr_q;
    assign sccb_wdata = wdata_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign cfg_busy   = busy_d;

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Directed bench for ov5640_cfg_ctrl: vector table of whole-run scenarios
// plus hand sequences for abort, stray ack and asynchronous reset.
module tb_ov5640_cfg_ctrl;

    localparam int TBL_DEPTH   = 4;
    localparam int CLK_PER_MS  = 10;
    localparam int SETTLE_MS   = 2;
    localparam int ACK_TIMEOUT = 40;
    localparam int ACK_DLY     = 10;
    localparam int SETTLE_CYC  = SETTLE_MS * CLK_PER_MS;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic        power_done;
    logic [7:0]  tbl_idx;
    logic [23:0] tbl_data;
    logic        sccb_req;
    logic [15:0] sccb_addr;
    logic [7:0]  sccb_wdata;
    logic        sccb_ack;
    logic        sccb_nack;
    logic        cfg_done;
    logic        cfg_err;
    logic        cfg_busy;

    logic [3:0][23:0] tbl_q;
    logic [31:0] nmask;
    logic        ack_en;
    logic        s_ack;
    logic        m_ack;
    logic        m_nack;
    int          wr_base;

    int          cyc = 0;
    int          wr_cnt = 0;
    int          err_cyc = 0;
    int          wait_q = 0;
    logic        req_p = 1'b0;
    logic        err_p = 1'b0;
    logic [15:0] wr_addr [64];
    logic [7:0]  wr_data [64];
    int          wr_cyc [64];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0][23:0] tbl;
        logic [31:0]      nmask;
        logic             ack_en;
        int               exp_wr;
        logic             exp_done;
        logic             exp_err;
        int               exp_idx;
        logic             chk_settle;
        logic             chk_gap;
        logic             chk_to;
    } vec_t;

    vec_t vecs [6];

    ov5640_cfg_ctrl #(
        .TBL_DEPTH  (TBL_DEPTH),
        .CLK_PER_MS (CLK_PER_MS),
        .SETTLE_MS  (SETTLE_MS),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .DELAY_ADDR (16'hFFFF)
    ) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .power_done(power_done),
        .tbl_idx   (tbl_idx),
        .tbl_data  (tbl_data),
        .sccb_req  (sccb_req),
        .sccb_addr (sccb_addr),
        .sccb_wdata(sccb_wdata),
        .sccb_ack  (sccb_ack),
        .sccb_nack (sccb_nack),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cfg_busy  (cfg_busy)
    );

    always #5 sclk = ~sclk;

    assign tbl_data  = tbl_q[tbl_idx[1:0]];
    assign sccb_ack  = m_ack | s_ack;
    assign sccb_nack = m_nack;

    always @(posedge sclk) cyc <= cyc + 1;

    // SCCB slave model and write logger, acting on the falling edge
    always @(negedge sclk) begin
        req_p  <= sccb_req;
        err_p  <= cfg_err;
        m_ack  <= 1'b0;
        m_nack <= 1'b0;
        if (sccb_req && !req_p && wr_cnt < 64) begin
            wr_addr[wr_cnt] <= sccb_addr;
            wr_data[wr_cnt] <= sccb_wdata;
            wr_cyc[wr_cnt]  <= cyc;
            wr_cnt          <= wr_cnt + 1;
        end
        if (cfg_err && !err_p) err_cyc <= cyc;
        if (!sccb_req || m_ack) begin
            wait_q <= 0;
        end else if (ack_en) begin
            if (wait_q == ACK_DLY - 1) begin
                m_ack  <= 1'b1;
                m_nack <= |((nmask >> (wr_cnt - 1 - wr_base)) & 32'd1);
                wait_q <= 0;
            end else begin
                wait_q <= wait_q + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][23:0] mk4(
        input logic [23:0] w0, input logic [23:0] w1,
        input logic [23:0] w2, input logic [23:0] w3);
        logic [3:0][23:0] r;
        r[0] = w0;
        r[1] = w1;
        r[2] = w2;
        r[3] = w3;
        return r;
    endfunction

    // Table word expected for write k: entries in order, delays skipped,
    // a NACKed write repeated on the next attempt.
    function automatic logic [23:0] exp_word(input vec_t v, input int k);
        int n = 0;
        for (int e = 0; e < 4; e++) begin
            if (v.tbl[e][23:8] == 16'hFFFF) continue;
            for (int a = 0; a < 4; a++) begin
                if (n == k) return v.tbl[e];
                n++;
                if (!v.nmask[n - 1]) break;
            end
        end
        return 24'h0;
    endfunction

    task automatic do_reset();
        s_rst_n    = 1'b0;
        power_done = 1'b0;
        s_ack      = 1'b0;
        repeat (3) @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);
    endtask

    task automatic wait_end(input string nm);
        for (int c = 0; c < 2000 && !(cfg_done || cfg_err); c++)
            @(negedge sclk);
        chk(nm, 32'(cfg_done | cfg_err), 32'd1);
    endtask

    logic [3:0][23:0] tA, tB, tC;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, n0, nw, gap, dl;

        tA = mk4({16'h3008, 8'h82}, {16'hFFFF, 8'h02},
                 {16'h3103, 8'h03}, {16'h3017, 8'hFF});
        tB = mk4({16'h3008, 8'h82}, {16'h3009, 8'h11},
                 {16'h300A, 8'h22}, {16'h300B, 8'h33});
        tC = mk4({16'hFFFF, 8'h00}, {16'h3008, 8'h82},
                 {16'hFFFF, 8'h01}, {16'h3103, 8'h03});

        vecs[0] = '{tA, 32'h0, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{tB, 32'h0, 1'b1, 4, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
`ifdef OV5640_CFG_RETRY_EN
        vecs[2] = '{tB, 32'hC, 1'b1, 6, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{tB, 32'h3C, 1'b1, 6, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
`else
        vecs[2] = '{tB, 32'h4, 1'b1, 3, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{tC, 32'h2, 1'b1, 2, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
`endif
        vecs[4] = '{tB, 32'h0, 1'b0, 1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{tC, 32'h0, 1'b1, 2, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};

        tbl_q      = tA;
        nmask      = '0;
        ack_en     = 1'b1;
        wr_base    = 0;
        s_ack      = 1'b0;
        power_done = 1'b0;
        s_rst_n    = 1'b0;
        #1;
        chk("rst_idx", 32'(tbl_idx), 32'd0);
        chk("rst_req", 32'(sccb_req), 32'd0);
        chk("rst_addr", 32'(sccb_addr), 32'd0);
        chk("rst_wdata", 32'(sccb_wdata), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            tbl_q   = vecs[i].tbl;
            nmask   = vecs[i].nmask;
            ack_en  = vecs[i].ack_en;
            wr_base = wr_cnt;
            p = cyc;
            power_done = 1'b1;
            wait_end($sformatf("v%0d_end", i));
            repeat (15) @(negedge sclk);
            nw = wr_cnt - wr_base;
            chk($sformatf("v%0d_done", i), 32'(cfg_done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_idx", i), 32'(tbl_idx), 32'(vecs[i].exp_idx));
            chk($sformatf("v%0d_req", i), 32'(sccb_req), 32'd0);
            chk($sformatf("v%0d_busy", i), 32'(cfg_busy), 32'd0);
            chk($sformatf("v%0d_nwr", i), 32'(nw), 32'(vecs[i].exp_wr));
            for (int k = 0; k < nw && k < vecs[i].exp_wr; k++)
                chk($sformatf("v%0d_wr%0d", i, k),
                    32'({wr_addr[wr_base + k], wr_data[wr_base + k]}),
                    32'(exp_word(vecs[i], k)));
            if (vecs[i].chk_settle && nw > 0) begin
                dl = wr_cyc[wr_base] - p - 1;
                chk($sformatf("v%0d_settle_lat=%0d", i, dl),
                    32'(dl >= SETTLE_CYC && dl <= SETTLE_CYC + 2), 32'd1);
            end
            if (vecs[i].chk_gap && nw > 1) begin
                gap = wr_cyc[wr_base + 1] - wr_cyc[wr_base];
                chk($sformatf("v%0d_gap=%0d", i, gap),
                    32'(gap >= 2 * CLK_PER_MS &&
                        gap <= 2 * CLK_PER_MS + ACK_DLY + 6), 32'd1);
            end
            if (vecs[i].chk_to && nw > 0)
                chk($sformatf("v%0d_timeout", i),
                    32'(err_cyc - wr_cyc[wr_base]), 32'(ACK_TIMEOUT));
        end

        // Abort while waiting on entry 2, stray ack in IDLE, then restart
        do_reset();
        tbl_q   = tB;
        nmask   = '0;
        ack_en  = 1'b1;
        wr_base = wr_cnt;
        power_done = 1'b1;
        for (int c = 0; c < 1000 && !(sccb_req && tbl_idx == 8'd2); c++)
            @(negedge sclk);
        chk("abort_reach", 32'(sccb_req && tbl_idx == 8'd2), 32'd1);
        ack_en     = 1'b0;
        power_done = 1'b0;
        @(posedge sclk);
        #1;
        chk("abort_req", 32'(sccb_req), 32'd0);
        chk("abort_busy", 32'(cfg_busy), 32'd0);
        chk("abort_idx", 32'(tbl_idx), 32'd0);
        chk("abort_done", 32'(cfg_done), 32'd0);
        chk("abort_err", 32'(cfg_err), 32'd0);
        n0 = wr_cnt;
        @(negedge sclk);
        s_ack = 1'b1;
        @(negedge sclk);
        s_ack = 1'b0;
        repeat (5) @(negedge sclk);
        chk("stray_busy", 32'(cfg_busy), 32'd0);
        chk("stray_req", 32'(sccb_req), 32'd0);
        chk("stray_nwr", 32'(wr_cnt - n0), 32'd0);
        chk("stray_err", 32'(cfg_err), 32'd0);
        ack_en  = 1'b1;
        wr_base = wr_cnt;
        power_done = 1'b1;
        wait_end("restart_end");
        repeat (3) @(negedge sclk);
        chk("restart_done", 32'(cfg_done), 32'd1);
        chk("restart_nwr", 32'(wr_cnt - wr_base), 32'd4);
        chk("restart_first", 32'({wr_addr[wr_base], wr_data[wr_base]}),
            32'(tB[0]));

        // Asynchronous reset while in the 2 ms delay entry
        do_reset();
        tbl_q   = tA;
        nmask   = '0;
        ack_en  = 1'b1;
        wr_base = wr_cnt;
        power_done = 1'b1;
        for (int c = 0; c < 1000 &&
             !(tbl_idx == 8'd1 && cfg_busy && !sccb_req); c++)
            @(negedge sclk);
        repeat (5) @(negedge sclk);
        chk("dly_idx", 32'(tbl_idx), 32'd1);
        chk("dly_addr", 32'(sccb_addr), 32'h3008);
        chk("dly_busy", 32'(cfg_busy), 32'd1);
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("arst_idx", 32'(tbl_idx), 32'd0);
        chk("arst_req", 32'(sccb_req), 32'd0);
        chk("arst_addr", 32'(sccb_addr), 32'd0);
        chk("arst_wdata", 32'(sccb_wdata), 32'd0);
        chk("arst_done", 32'(cfg_done), 32'd0);
        chk("arst_err", 32'(cfg_err), 32'd0);
        chk("arst_busy", 32'(cfg_busy), 32'd0);
        power_done = 1'b0;
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
